// File: rtl/acc_stream_64_if.sv
// Valid/ready stream bundle for acc_stream_64.
// The sample input and the sum output are carried together.
// The master side is the producer/consumer environment.
// The slave side is the accumulator.
interface acc_stream_64_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum
  );
endinterface

// File: rtl/acc_stream_64.sv
// Frame accumulator: sums FRAME_LEN unsigned 32-bit samples into a 64-bit result.
// The low word is formed by a combinational 32-bit adder.
// Its carry-out bumps the high word.
// Every output is a registered flag or register, so no input reaches an output combinationally.

// Purely combinational 32-bit adder with carry-out.
module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        C32
);
  // A 33-bit add gives the sum and the carry-out together.
  always_comb begin
    {C32, S} = {1'b0, A} + {1'b0, B};
  end
endmodule

module acc_stream_64 #(
  parameter int FRAME_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  acc_stream_64_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The beat index of the final sample; the counter holds beats accepted so far.
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t      state;
  logic [31:0] acc_lo;
  logic [31:0] acc_hi;
  logic [15:0] cnt;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic [31:0] sum_lo;
  logic        carry;
  logic        beat;
  logic        last_beat;

  adder_32bit u_add (
    .A   (acc_lo),
    .B   (bus.in_data),
    .S   (sum_lo),
    .C32 (carry)
  );

  // Beat qualification: in_ready_q is high only in ACCUM, so this also encodes the state.
  always_comb begin
    beat      = bus.in_valid && in_ready_q;
    last_beat = beat && (cnt == LAST_IDX);
  end

  // Frame control, accumulation and registered output flags.
  // abort wins over a coincident final beat, which is then dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_lo      <= 32'h0;
      acc_hi      <= 32'h0;
      cnt         <= 16'h0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_lo     <= 32'h0;
            acc_hi     <= 32'h0;
            cnt        <= 16'h0;
            state      <= ACCUM;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (abort) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (beat) begin
            acc_lo <= sum_lo;
            acc_hi <= acc_hi + {31'h0, carry};
            cnt    <= cnt + 16'd1;
            if (last_beat) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = {acc_hi, acc_lo};
  assign busy          = busy_q;

endmodule

// File: tb/tb_acc_stream_64.sv
// Directed bench for acc_stream_64.
// Instance u4 uses FRAME_LEN=4 and instance u1 uses FRAME_LEN=1.
// Expected values are hand-computed constants.
module tb_acc_stream_64;

  logic clk;
  logic rst_n;
  logic start4, abort4, busy4;
  logic start1, abort1, busy1;
  int   checks;
  int   failures;

  acc_stream_64_if if4 ();
  acc_stream_64_if if1 ();

  acc_stream_64 #(.FRAME_LEN(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .abort (abort4),
    .busy  (busy4),
    .bus   (if4)
  );

  acc_stream_64 #(.FRAME_LEN(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .abort (abort1),
    .busy  (busy1),
    .bus   (if1)
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected instance, then advance to #1 after the edge.
  task automatic applyStimulus(input int unit, input logic st, input logic ab,
                               input logic iv, input logic [31:0] d, input logic ordy);
    start4 = 1'b0; abort4 = 1'b0; if4.in_valid = 1'b0; if4.in_data = 32'h0; if4.out_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; if1.in_valid = 1'b0; if1.in_data = 32'h0; if1.out_ready = 1'b0;
    if (unit == 4) begin
      start4 = st; abort4 = ab; if4.in_valid = iv; if4.in_data = d; if4.out_ready = ordy;
    end else begin
      start1 = st; abort1 = ab; if1.in_valid = iv; if1.in_data = d; if1.out_ready = ordy;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"},  {63'h0, if4.in_ready},  64'h0);
    checkOutput({tag, "_out_valid"}, {63'h0, if4.out_valid}, 64'h0);
    checkOutput({tag, "_busy"},      {63'h0, busy4},         64'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; if4.in_valid = 1'b0; if4.in_data = 32'h0; if4.out_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; if1.in_valid = 1'b0; if1.in_data = 32'h0; if1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("rst");
    checkOutput("rst_sum", if4.out_sum, 64'h0);
    rst_n = 1'b1;

    // Test 1: back-to-back 1,2,3,4.
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    checkOutput("t1_start_in_ready", {63'h0, if4.in_ready}, 64'h1);
    checkOutput("t1_start_busy",     {63'h0, busy4},        64'h1);
    applyStimulus(4, 0, 0, 1, 32'd1, 1);
    applyStimulus(4, 0, 0, 1, 32'd2, 1);
    applyStimulus(4, 0, 0, 1, 32'd3, 1);
    checkOutput("t1_b3_out_valid", {63'h0, if4.out_valid}, 64'h0);
    checkOutput("t1_b3_sum",       if4.out_sum,            64'h6);
    applyStimulus(4, 0, 0, 1, 32'd4, 1);
    checkOutput("t1_done_out_valid", {63'h0, if4.out_valid}, 64'h1);
    checkOutput("t1_done_in_ready",  {63'h0, if4.in_ready},  64'h0);
    checkOutput("t1_done_sum",       if4.out_sum,            64'hA);
    applyStimulus(4, 0, 0, 0, 32'h0, 1);
    checkIdle("t1_after");

    // Test 2: all-ones beats with gaps; a start during ACCUM must be ignored.
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    applyStimulus(4, 0, 0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("t2_b1_sum", if4.out_sum, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    checkOutput("t2_gap1_sum", if4.out_sum, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(4, 0, 0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("t2_b2_sum", if4.out_sum, 64'h0000_0001_FFFF_FFFE);
    applyStimulus(4, 0, 0, 0, 32'h1234_5678, 0);
    checkOutput("t2_gap2_sum", if4.out_sum, 64'h0000_0001_FFFF_FFFE);
    applyStimulus(4, 0, 0, 1, 32'hFFFF_FFFF, 0);
    applyStimulus(4, 0, 0, 0, 32'h0, 0);
    checkOutput("t2_b3_out_valid", {63'h0, if4.out_valid}, 64'h0);
    applyStimulus(4, 0, 0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("t2_done_out_valid", {63'h0, if4.out_valid}, 64'h1);
    checkOutput("t2_done_sum",       if4.out_sum,            64'h0000_0003_FFFF_FFFC);
    applyStimulus(4, 0, 0, 0, 32'h0, 1);
    checkIdle("t2_after");

    // Test 3: output backpressure for five cycles, with a start pulse in DONE.
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    applyStimulus(4, 0, 0, 1, 32'd1, 0);
    applyStimulus(4, 0, 0, 1, 32'd2, 0);
    applyStimulus(4, 0, 0, 1, 32'd3, 0);
    applyStimulus(4, 0, 0, 1, 32'd4, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4, (i == 2), 0, 1, 32'd7, 0);
      checkOutput("t3_hold_out_valid", {63'h0, if4.out_valid}, 64'h1);
      checkOutput("t3_hold_in_ready",  {63'h0, if4.in_ready},  64'h0);
      checkOutput("t3_hold_sum",       if4.out_sum,            64'hA);
    end
    applyStimulus(4, 0, 0, 0, 32'h0, 1);
    checkIdle("t3_after");

    // Test 4: abort coincident with the final beat, then a fresh frame.
    applyStimulus(4, 0, 1, 0, 32'h0, 0);
    checkIdle("t4_idle_abort");
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    applyStimulus(4, 0, 0, 1, 32'd1, 0);
    applyStimulus(4, 0, 0, 1, 32'd2, 0);
    applyStimulus(4, 0, 0, 1, 32'd3, 0);
    applyStimulus(4, 0, 1, 1, 32'd4, 1);
    checkIdle("t4_abort");
    checkOutput("t4_abort_sum", if4.out_sum, 64'h6);
    applyStimulus(4, 0, 0, 0, 32'h0, 1);
    checkOutput("t4_quiet_out_valid", {63'h0, if4.out_valid}, 64'h0);
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    checkOutput("t4_clear_sum", if4.out_sum, 64'h0);
    for (int i = 0; i < 4; i++) applyStimulus(4, 0, 0, 1, 32'd5, 0);
    checkOutput("t4_done_out_valid", {63'h0, if4.out_valid}, 64'h1);
    checkOutput("t4_done_sum",       if4.out_sum,            64'h14);
    applyStimulus(4, 0, 0, 0, 32'h0, 1);
    checkIdle("t4_after");

    // Test 5: asynchronous reset mid-frame, then a clean frame.
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    applyStimulus(4, 0, 0, 1, 32'd9, 0);
    applyStimulus(4, 0, 0, 1, 32'd9, 0);
    if4.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("t5_rst");
    checkOutput("t5_rst_sum", if4.out_sum, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkIdle("t5_release");
    applyStimulus(4, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(4, 0, 0, 1, 32'd1, 0);
    checkOutput("t5_done_out_valid", {63'h0, if4.out_valid}, 64'h1);
    checkOutput("t5_done_sum",       if4.out_sum,            64'h4);
    applyStimulus(4, 0, 0, 0, 32'h0, 1);
    checkIdle("t5_after");

    // Test 6: FRAME_LEN=1, one beat completes the frame.
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    checkOutput("t6_start_in_ready", {63'h0, if1.in_ready}, 64'h1);
    applyStimulus(1, 0, 0, 1, 32'h8000_0000, 0);
    checkOutput("t6_done_out_valid", {63'h0, if1.out_valid}, 64'h1);
    checkOutput("t6_done_in_ready",  {63'h0, if1.in_ready},  64'h0);
    checkOutput("t6_done_sum",       if1.out_sum,            64'h0000_0000_8000_0000);
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    checkOutput("t6_after_out_valid", {63'h0, if1.out_valid}, 64'h0);
    checkOutput("t6_after_busy",      {63'h0, busy1},         64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_stream_64.md
# acc_stream_64

Frame accumulator that sits directly downstream of `adder_32bit`. It consumes a stream of 32-bit unsigned samples over a valid/ready handshake and sums a fixed-length frame into a 64-bit result. The low word is formed by an instantiated `adder_32bit`, with A = accumulator low word and B = sample. Its `S` output is registered as the new low word, and its `C32` output increments the high word. The finished sum is presented on a valid/ready output port.

## Interface

- `FRAME_LEN`, 16, samples per frame; legal range 1..65535
- `clk`  input  1  clock, rising-edge
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  single-cycle request to begin a frame; honoured only in IDLE
- `abort`  input  1  discard the current frame; honoured only in ACCUM
- `in_valid`  input  1  `in_data` valid
- `in_ready`  output  1  block accepts a sample this cycle
- `in_data`  input  32  unsigned sample
- `out_valid`  output  1  `out_sum` valid
- `out_ready`  input  1  consumer takes the result
- `out_sum`  output  64  frame sum
- `busy`  output  1  state is not IDLE

## Operation

- States: IDLE, ACCUM, DONE; 2-bit state register.
- IDLE:
  - `start`=1 → clear accumulator (64'h0) and beat counter (16'h0); next state ACCUM.
  - `abort` is ignored.
- ACCUM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid` && `in_ready`. On a beat:
    - acc_lo ← `S` (acc_lo + `in_data`, mod 2^32)
    - acc_hi ← acc_hi + `C32` (mod 2^32)
    - counter increments.
  - If the accepted beat is beat number `FRAME_LEN`, next state is DONE.
  - `abort`=1 → next state IDLE. Accumulator contents are left as-is and no output is produced. `abort` takes precedence over a simultaneous final beat; that beat is dropped.
  - `start` is ignored.
- DONE:
  - `out_valid`=1 and `in_ready`=0.
  - `out_sum` = {acc_hi, acc_lo}, held stable while `out_valid`=1 and `out_ready`=0.
  - `out_ready`=1 → next state IDLE.
  - `start` and `abort` are ignored.
- `in_valid` may drop between beats (gaps). Nothing changes on non-beat cycles.
- Width rule: the maximum frame sum is 65535 × (2^32−1) < 2^48, so acc_hi cannot wrap for legal `FRAME_LEN`. No overflow flag.
- Reset (asserted at any time, including mid-frame or while DONE): state IDLE, accumulator 0, counter 0.
  - Outputs go to `in_ready`=0, `out_valid`=0, `out_sum`=64'h0, `busy`=0.
  - A pending result is lost.

## Timing

- All outputs are decoded from registers only; there is no input-to-output combinational path. In particular `in_ready` depends on state alone, not on `in_valid`.
- `start` sampled at edge t → `in_ready`=1 and `busy`=1 after edge t.
- Throughput in ACCUM: one beat per cycle.
- Final beat accepted at edge k:
  - `out_valid`=1 and `in_ready`=0 after edge k.
  - `out_sum` includes that beat.
  - Minimum frame latency is `FRAME_LEN`+1 cycles from `start`.
- `out_ready` sampled high at edge m while DONE → `out_valid`=0 and `busy`=0 after edge m.
  - The earliest next `start` is sampled at edge m+1.
- `FRAME_LEN`=1 → a single beat moves ACCUM to DONE.
- `abort` sampled at edge a while ACCUM → `in_ready`=0 and `busy`=0 after edge a.
- `adder_32bit` is purely combinational. Its path (acc_lo, `in_data`) → `S`/`C32` → registers must close in one cycle.

## Test plan

- `FRAME_LEN`=4, `start`, then beats 1, 2, 3, 4 back-to-back, `out_ready`=1 → `out_valid` one cycle after the 4th beat, `out_sum`=64'h0000_0000_0000_000A, IDLE the following cycle.
- `FRAME_LEN`=4, beats 32'hFFFF_FFFF ×4 with 1-cycle `in_valid` gaps → `out_sum`=64'h0000_0003_FFFF_FFFC. The carry chain is exercised on every beat, and there are no beats on gap cycles.
- Output backpressure: result 64'h0000_0000_0000_000A with `out_ready`=0 for 5 cycles → `out_valid` stays 1 and `out_sum` is stable. `in_ready`=0 throughout, and a `start` pulse during DONE is ignored. `out_ready`=1 → IDLE.
- `abort` asserted coincident with the 4th beat → no `out_valid`, IDLE next cycle. A new frame of 5, 5, 5, 5 then yields `out_sum`=64'h14, proving the accumulator is cleared on `start`.
- `rst_n` pulled low after beat 2 of a frame (asynchronous, mid-cycle) → all outputs 0 immediately. After release, a full frame of 1, 1, 1, 1 gives `out_sum`=64'h4.
- `FRAME_LEN`=1, beat 32'h8000_0000 → `out_valid` after the single beat, `out_sum`=64'h0000_0000_8000_0000.
